knn_local_buf_ctrl: RTL and testbench

- Controller for one single-port 256-bit x 2048 local URAM buffer of a partial-KNN kernel; drives the buffer's address0/ce0/we0/d0 and consumes q0.
- LOAD command: writes an incoming stream of search-set words into the buffer.
- SCAN command: reads the stored words back as an output stream to the distance-compute stage.
- Absorbs memory read latency and downstream backpressure with a small credit-tracked output FIFO.

---
 rtl/knn_buf_pkg.sv | 10 +
 rtl/knn_buf_out_fifo.sv | 49 ++++
 rtl/knn_local_buf_ctrl.sv | 138 +++++++++++++
 tb/tb_knn_local_buf_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/knn_buf_pkg.sv
// Shared types and defaults for the partial-KNN local buffer controller.
package knn_buf_pkg;
    localparam int DATA_W_DEF = 256;
    localparam int ADDR_W_DEF = 11;

    localparam logic MODE_LOAD = 1'b0;
    localparam logic MODE_SCAN = 1'b1;

    typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;
endpackage

// File: rtl/knn_buf_out_fifo.sv
// First-word fall-through FIFO: a push into an empty FIFO is visible at the head in the same cycle.
// Caller must keep push within capacity (credit-tracked upstream); pop is ignored when nothing is available.
module knn_buf_out_fifo #(
    parameter int DATA_W = 256,
    parameter int DEPTH  = 3,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic [CNT_W-1:0]  count,
    output logic              empty
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              store;
    logic              from_mem;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty    = (count == '0);
    // A word pushed and popped in the same cycle while empty bypasses storage.
    assign from_mem = pop && !empty;
    assign store    = push && !(pop && empty);
    assign pop_data = empty ? push_data : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (store)    wr_ptr <= next_ptr(wr_ptr);
            if (from_mem) rd_ptr <= next_ptr(rd_ptr);
            count <= count + CNT_W'(store) - CNT_W'(from_mem);
        end
    end

    always_ff @(posedge clk) begin
        if (store) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/knn_local_buf_ctrl.sv
// LOAD/SCAN controller for one single-port local buffer; LOAD writes per beat with zero latency, SCAN first word MEM_LAT+1 after the command.
// SCAN reads are credit-limited against the output FIFO, so out_ready low stalls issue without loss.
module knn_local_buf_ctrl
    import knn_buf_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DEPTH   = 2 ** ADDR_W,
    parameter int MEM_LAT = 1,
    parameter int FIFO_D  = MEM_LAT + 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_mode,
    input  logic [ADDR_W:0]   cmd_len,
    output logic              done,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [ADDR_W-1:0] mem_address0,
    output logic              mem_ce0,
    output logic              mem_we0,
    output logic [DATA_W-1:0] mem_d0,
    input  logic [DATA_W-1:0] mem_q0
);
    localparam int LEN_W  = ADDR_W + 1;
    localparam int FCNT_W = $clog2(FIFO_D + 1);
    localparam int CR_W   = FCNT_W + 1;

    state_t             state, nstate;
    logic [LEN_W-1:0]   len_q, wr_cnt, rd_issued, rd_popped;
    logic [MEM_LAT-1:0] vld_sr;
    logic [CR_W-1:0]    inflight;
    logic [FCNT_W-1:0]  fifo_count;
    logic               fifo_empty, fifo_push, issue, pop, len_ok;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_LAT; i++) inflight = inflight + CR_W'(vld_sr[i]);
    end

    // Counting in-flight reads as FIFO occupancy means every issued read has a slot waiting.
    assign issue     = (state == SCAN) && (rd_issued < len_q)
                       && ((inflight + CR_W'(fifo_count)) < CR_W'(FIFO_D));
    assign fifo_push = vld_sr[MEM_LAT-1];
    assign out_valid = (state == SCAN) && (!fifo_empty || fifo_push);
    assign out_last  = out_valid && (rd_popped == len_q - LEN_W'(1));
    assign pop       = out_valid && out_ready;
    assign len_ok    = (cmd_len != '0) && (cmd_len <= LEN_W'(DEPTH));

    always_comb begin
        nstate       = state;
        cmd_ready    = 1'b0;
        in_ready     = 1'b0;
        done         = 1'b0;
        mem_ce0      = 1'b0;
        mem_we0      = 1'b0;
        mem_address0 = '0;
        mem_d0       = '0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (!len_ok)                    nstate = DONE;
                    else if (cmd_mode == MODE_LOAD) nstate = LOAD;
                    else                            nstate = SCAN;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mem_ce0      = 1'b1;
                    mem_we0      = 1'b1;
                    mem_address0 = wr_cnt[ADDR_W-1:0];
                    mem_d0       = in_data;
                    if (wr_cnt == len_q - LEN_W'(1)) nstate = DONE;
                end
            end
            SCAN: begin
                if (issue) begin
                    mem_ce0      = 1'b1;
                    mem_address0 = rd_issued[ADDR_W-1:0];
                end
                if (pop && out_last) nstate = DONE;
            end
            DONE: begin
                done   = 1'b1;
                nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            len_q     <= '0;
            wr_cnt    <= '0;
            rd_issued <= '0;
            rd_popped <= '0;
            vld_sr    <= '0;
        end else begin
            state     <= nstate;
            vld_sr[0] <= issue;
            for (int i = 1; i < MEM_LAT; i++) vld_sr[i] <= vld_sr[i-1];
            if (state == IDLE && cmd_valid) begin
                len_q     <= cmd_len;
                wr_cnt    <= '0;
                rd_issued <= '0;
                rd_popped <= '0;
            end else begin
                if (state == LOAD && in_valid) wr_cnt <= wr_cnt + LEN_W'(1);
                if (issue)                     rd_issued <= rd_issued + LEN_W'(1);
                if (pop)                       rd_popped <= rd_popped + LEN_W'(1);
            end
        end
    end

    knn_buf_out_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_D)
    ) u_out_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (fifo_push),
        .push_data (mem_q0),
        .pop       (pop),
        .pop_data  (out_data),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );
endmodule

// File: tb/tb_knn_local_buf_ctrl.sv
// Directed bench for knn_local_buf_ctrl with a behavioural single-port buffer of MEM_LAT read latency.
module tb_knn_local_buf_ctrl;
    localparam int DATA_W  = 256;
    localparam int ADDR_W  = 11;
    localparam int DEPTH   = 2048;
    localparam int MEM_LAT = 3;
    localparam int FIFO_D  = MEM_LAT + 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_mode = 1'b0;
    logic [ADDR_W:0]   cmd_len = '0;
    logic              done;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              out_last;
    logic [ADDR_W-1:0] mem_address0;
    logic              mem_ce0, mem_we0;
    logic [DATA_W-1:0] mem_d0, mem_q0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    knn_local_buf_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .MEM_LAT(MEM_LAT), .FIFO_D(FIFO_D)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode), .cmd_len(cmd_len),
        .done(done),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .mem_address0(mem_address0), .mem_ce0(mem_ce0), .mem_we0(mem_we0),
        .mem_d0(mem_d0), .mem_q0(mem_q0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Buffer model: write on the edge, read data appears MEM_LAT cycles after ce0.
    logic [DATA_W-1:0] mem_arr [DEPTH];
    logic [DATA_W-1:0] q_pipe  [MEM_LAT];
    always @(posedge clk) begin
        if (mem_ce0 && mem_we0) mem_arr[mem_address0] <= mem_d0;
        q_pipe[0] <= mem_arr[mem_address0];
        for (int i = 1; i < MEM_LAT; i++) q_pipe[i] <= q_pipe[i-1];
    end
    assign mem_q0 = q_pipe[MEM_LAT-1];

    // Bench's own picture of what the buffer should hold.
    logic [DATA_W-1:0] exp_dat [DEPTH];

    int                wr_addr_q[$];
    logic [DATA_W-1:0] wr_dat_q[$];
    logic [DATA_W-1:0] out_q[$];
    bit                last_q[$];
    int rd_cnt, max_rd_addr, ce_cnt, bad_we, done_cnt, hs_cyc, done_cyc, first_out_cyc, max_fcnt;

    always @(negedge clk) begin
        if (reset) begin
            if (cmd_valid && cmd_ready) hs_cyc = cyc;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (mem_ce0) ce_cnt++;
            if (mem_ce0 && mem_we0) begin wr_addr_q.push_back(int'(mem_address0)); wr_dat_q.push_back(mem_d0); end
            if (mem_we0 && !(in_valid && in_ready)) bad_we++;
            if (mem_ce0 && !mem_we0) begin
                rd_cnt++;
                if (int'(mem_address0) > max_rd_addr) max_rd_addr = int'(mem_address0);
            end
            if (out_valid && first_out_cyc < 0) first_out_cyc = cyc;
            if (out_valid && out_ready) begin out_q.push_back(out_data); last_q.push_back(out_last); end
            if (int'(dut.u_out_fifo.count) > max_fcnt) max_fcnt = int'(dut.u_out_fifo.count);
        end
    end

    task automatic clear_mon();
        wr_addr_q.delete(); wr_dat_q.delete(); out_q.delete(); last_q.delete();
        rd_cnt = 0; max_rd_addr = -1; ce_cnt = 0; bad_we = 0; done_cnt = 0;
        hs_cyc = -1; done_cyc = -1; first_out_cyc = -1; max_fcnt = 0;
    endtask

    task automatic send_cmd(input logic mode, input int len);
        clear_mon();
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_mode = mode; cmd_len = (ADDR_W+1)'(len);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done_cyc < 0 && n < 8000) begin @(negedge clk); #1; n++; end
        checks++;
        if (done_cyc < 0) begin errors++; $display("FAIL %s_done_timeout: got no done pulse, required one", name); end
    endtask

    task automatic do_load(input int len, input bit gaps);
        int sent = 0;
        int n = 0;
        send_cmd(1'b0, len);
        while (sent < len && n < 20000) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = exp_dat[sent];
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        wait_done("load");
    endtask

    task automatic do_scan(input int len, input int duty, input int abort_after);
        int n = 0;
        send_cmd(1'b1, len);
        while (done_cyc < 0 && n < 20000) begin
            out_ready = (duty <= 1) ? 1'b1 : ((n % duty) == 0);
            @(negedge clk); #1;
            n++;
            if (abort_after > 0 && out_q.size() >= abort_after) break;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        if (abort_after == 0) begin
            checks++;
            if (done_cyc < 0) begin errors++; $display("FAIL scan_done_timeout: got no done pulse, required one"); end
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready); end
        checks++;
        if ({done, in_ready, out_valid, out_last, mem_ce0, mem_we0} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl_outs: got %b required 000000", {done, in_ready, out_valid, out_last, mem_ce0, mem_we0});
        end
        checks++;
        if (mem_address0 !== '0 || mem_d0 !== '0) begin
            errors++; $display("FAIL reset_mem_bus: got addr %0d d0 %h required 0", mem_address0, mem_d0);
        end
        @(posedge clk); #1 reset = 1'b1;
    endtask

    task automatic test_load_scan();
        int bad = -1;
        int lmask = 0;
        for (int i = 0; i < 4; i++) exp_dat[i] = DATA_W'(32'hA0 + i);
        do_load(4, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (wr_addr_q.size() != 4) begin errors++; $display("FAIL ls_wr_count: got %0d required 4", wr_addr_q.size()); end
        for (int i = 0; i < wr_addr_q.size(); i++)
            if (bad < 0 && (wr_addr_q[i] != i || wr_dat_q[i] !== exp_dat[i])) bad = i;
        checks++;
        if (bad >= 0) begin errors++; $display("FAIL ls_wr_beat: beat %0d got addr %0d data %h required addr %0d data %h", bad, wr_addr_q[bad], wr_dat_q[bad], bad, exp_dat[bad]); end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL ls_load_done_cnt: got %0d required 1", done_cnt); end

        do_scan(4, 1, 0);
        repeat (3) @(negedge clk);
        checks++;
        if (out_q.size() != 4) begin errors++; $display("FAIL ls_scan_count: got %0d required 4", out_q.size()); end
        bad = -1;
        for (int i = 0; i < out_q.size(); i++) begin
            if (bad < 0 && out_q[i] !== exp_dat[i]) bad = i;
            if (last_q[i]) lmask |= (1 << i);
        end
        checks++;
        if (bad >= 0) begin errors++; $display("FAIL ls_scan_data: word %0d got %h required %h", bad, out_q[bad], exp_dat[bad]); end
        checks++;
        if (lmask != 8) begin errors++; $display("FAIL ls_scan_last: got mask %0h required 8", lmask); end
        checks++;
        if (first_out_cyc - hs_cyc != MEM_LAT + 1) begin
            errors++; $display("FAIL ls_scan_latency: got %0d required %0d", first_out_cyc - hs_cyc, MEM_LAT + 1);
        end
        checks++;
        if (done_cyc - first_out_cyc != 4) begin errors++; $display("FAIL ls_scan_bubbles: got %0d cycles required 4", done_cyc - first_out_cyc); end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL ls_scan_done_cnt: got %0d required 1", done_cnt); end
    endtask

    task automatic test_full_buffer();
        int bad = -1;
        int nlast = 0;
        for (int i = 0; i < DEPTH; i++) exp_dat[i] = DATA_W'(i);
        do_load(DEPTH, 1'b0);
        for (int i = 0; i < wr_addr_q.size(); i++)
            if (bad < 0 && (wr_addr_q[i] != i || wr_dat_q[i] !== exp_dat[i])) bad = i;
        checks++;
        if (wr_addr_q.size() != DEPTH || bad >= 0) begin
            errors++; $display("FAIL full_load: got %0d writes, first bad beat %0d; required %0d contiguous", wr_addr_q.size(), bad, DEPTH);
        end
        do_scan(DEPTH, 1, 0);
        bad = -1;
        for (int i = 0; i < out_q.size(); i++) begin
            if (bad < 0 && out_q[i] !== exp_dat[i]) bad = i;
            if (last_q[i]) nlast++;
        end
        checks++;
        if (out_q.size() != DEPTH || bad >= 0) begin
            errors++; $display("FAIL full_scan_data: got %0d words, first bad index %0d; required %0d in order", out_q.size(), bad, DEPTH);
        end
        checks++;
        if (nlast != 1 || out_q.size() != DEPTH || !last_q[DEPTH-1]) begin
            errors++; $display("FAIL full_scan_last: got %0d last flags, required exactly one on word %0d", nlast, DEPTH - 1);
        end
        checks++;
        if (rd_cnt != DEPTH || max_rd_addr != DEPTH - 1) begin
            errors++; $display("FAIL full_scan_reads: got %0d reads max addr %0d required %0d reads max addr %0d", rd_cnt, max_rd_addr, DEPTH, DEPTH - 1);
        end
    endtask

    task automatic test_backpressure();
        int bad = -1;
        for (int i = 0; i < 16; i++) exp_dat[i] = DATA_W'(32'hC000 + 3 * i);
        do_load(16, 1'b0);
        do_scan(16, 3, 0);
        for (int i = 0; i < out_q.size(); i++)
            if (bad < 0 && out_q[i] !== exp_dat[i]) bad = i;
        checks++;
        if (out_q.size() != 16 || bad >= 0) begin
            errors++; $display("FAIL bp_data: got %0d words, first bad index %0d; required 16 in order", out_q.size(), bad);
        end
        checks++;
        if (max_fcnt > FIFO_D) begin errors++; $display("FAIL bp_fifo_count: got max %0d required <= %0d", max_fcnt, FIFO_D); end
        checks++;
        if (rd_cnt != 16) begin errors++; $display("FAIL bp_reads: got %0d required 16", rd_cnt); end
    endtask

    task automatic test_load_gaps();
        int bad = -1;
        for (int i = 0; i < 8; i++) exp_dat[i] = DATA_W'(32'h7700 + i);
        do_load(8, 1'b1);
        checks++;
        if (bad_we != 0) begin errors++; $display("FAIL gaps_we_no_beat: got %0d stray writes required 0", bad_we); end
        for (int i = 0; i < wr_addr_q.size(); i++)
            if (bad < 0 && (wr_addr_q[i] != i || wr_dat_q[i] !== exp_dat[i])) bad = i;
        checks++;
        if (wr_addr_q.size() != 8 || bad >= 0) begin
            errors++; $display("FAIL gaps_addrs: got %0d writes, first bad beat %0d; required 8 contiguous", wr_addr_q.size(), bad);
        end
    endtask

    task automatic test_edge_lengths();
        int lens[4]  = '{0, 0, 3000, 4095};
        bit modes[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) begin
            send_cmd(modes[k], lens[k]);
            wait_done("edge");
            checks++;
            if (done_cyc - hs_cyc != 1 || ce_cnt != 0) begin
                errors++; $display("FAIL edge_len_%0d: got done after %0d cycles ce0 %0d times, required 1 and 0", lens[k], done_cyc - hs_cyc, ce_cnt);
            end
        end
        do_scan(1, 1, 0);
        checks++;
        if (out_q.size() != 1 || out_q[0] !== exp_dat[0] || !last_q[0]) begin
            errors++; $display("FAIL edge_len_1: got %0d words, required one word %h with out_last", out_q.size(), exp_dat[0]);
        end
    endtask

    task automatic test_reset_mid_scan();
        int bad = -1;
        for (int i = 0; i < 10; i++) exp_dat[i] = DATA_W'(32'hD00 + i);
        do_load(10, 1'b0);
        do_scan(10, 1, 5);
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || mem_ce0 !== 1'b0) begin
            errors++; $display("FAIL rst_mid_outs: got out_valid %b ce0 %b required 0 0", out_valid, mem_ce0);
        end
        @(posedge clk); #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || done_cnt != 0) begin
            errors++; $display("FAIL rst_mid_idle: got cmd_ready %b done %0d required 1 0", cmd_ready, done_cnt);
        end
        do_scan(2, 1, 0);
        for (int i = 0; i < out_q.size(); i++)
            if (bad < 0 && (out_q[i] !== exp_dat[i] || last_q[i] != (i == 1))) bad = i;
        checks++;
        if (out_q.size() != 2 || bad >= 0) begin
            errors++; $display("FAIL rst_mid_rescan: got %0d words, first bad index %0d; required 2 words with last on 1", out_q.size(), bad);
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_load_scan();
        test_full_buffer();
        test_backpressure();
        test_load_gaps();
        test_edge_lengths();
        test_reset_mid_scan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
